// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, one-word-per-line instruction cache between the decoder and memctrl.
// Optional macro ICACHE_STATS_EN adds the hit_cnt/miss_cnt lookup counters.
module icache_dm #(
  parameter int INDEX_WIDTH = 6,
  parameter int ADDR_WIDTH  = 18
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] inst,
  output logic        mem_if_enable,
  output logic [31:0] mem_if_addr,
  input  logic        mem_if_ready,
  input  logic [31:0] mem_inst
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]     valid;
  logic [TAG_WIDTH-1:0] tag_arr  [LINES];
  logic [31:0]          data_arr [LINES];

  logic [INDEX_WIDTH-1:0] req_index, req_index_nxt;
  logic [TAG_WIDTH-1:0]   req_tag, req_tag_nxt;
  logic                   req_cacheable, req_cacheable_nxt;

  logic        if_ready_nxt;
  logic [31:0] inst_nxt;
  logic        mem_en_nxt;
  logic [31:0] mem_addr_nxt;
  logic        fill_we;

  logic [INDEX_WIDTH-1:0] index;
  logic [TAG_WIDTH-1:0]   tag;
  logic                   cacheable;
  logic                   hit;
  logic                   unused_addr_bits;

  assign index     = if_addr[INDEX_WIDTH+1:2];
  assign tag       = if_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
  // The 0x3xxxx window is device space: always fetched, never allocated.
  assign cacheable = (if_addr[17:16] != 2'b11);
  assign hit       = cacheable && valid[index] && (tag_arr[index] == tag);
  assign unused_addr_bits = ^if_addr[1:0];

  always_comb begin
    state_nxt         = state;
    if_ready_nxt      = if_ready;
    inst_nxt          = inst;
    mem_en_nxt        = mem_if_enable;
    mem_addr_nxt      = mem_if_addr;
    req_index_nxt     = req_index;
    req_tag_nxt       = req_tag;
    req_cacheable_nxt = req_cacheable;
    fill_we           = 1'b0;

    if (clear) begin
      // Flush drops any refill in flight; lines already filled stay valid.
      state_nxt    = IDLE;
      if_ready_nxt = 1'b0;
      mem_en_nxt   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if_ready_nxt = 1'b0;
          if (if_enable) begin
            if (hit) begin
              inst_nxt     = data_arr[index];
              if_ready_nxt = 1'b1;
              state_nxt    = RESP;
            end else begin
              mem_en_nxt        = 1'b1;
              mem_addr_nxt      = {if_addr[31:2], 2'b00};
              req_index_nxt     = index;
              req_tag_nxt       = tag;
              req_cacheable_nxt = cacheable;
              state_nxt         = REFILL;
            end
          end
        end
        REFILL: begin
          if (mem_if_ready) begin
            fill_we      = req_cacheable;
            inst_nxt     = mem_inst;
            if_ready_nxt = 1'b1;
            mem_en_nxt   = 1'b0;
            state_nxt    = RESP;
          end
        end
        RESP: begin
          if_ready_nxt = 1'b0;
          state_nxt    = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      if_ready      <= 1'b0;
      inst          <= '0;
      mem_if_enable <= 1'b0;
      mem_if_addr   <= '0;
      req_index     <= '0;
      req_tag       <= '0;
      req_cacheable <= 1'b0;
      valid         <= '0;
    end else if (rdy_in) begin
      state         <= state_nxt;
      if_ready      <= if_ready_nxt;
      inst          <= inst_nxt;
      mem_if_enable <= mem_en_nxt;
      mem_if_addr   <= mem_addr_nxt;
      req_index     <= req_index_nxt;
      req_tag       <= req_tag_nxt;
      req_cacheable <= req_cacheable_nxt;
      if (fill_we) begin
        valid[req_index] <= 1'b1;
      end
    end
  end

  // Tag/data storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_we) begin
      tag_arr[req_index]  <= req_tag;
      data_arr[req_index] <= mem_inst;
    end
  end

`ifdef ICACHE_STATS_EN
  logic lookup;
  assign lookup = (state == IDLE) && if_enable && !clear;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy_in && lookup) begin
      if (hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end else begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: scoreboard bench for icache_dm with directed cases and a randomized fetch stream.
// The reference model tracks per-line valid/tag/data from the cache rules; a monitor checks every if_ready.
module tb_icache_dm;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        if_enable;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] inst;
  logic        mem_if_enable;
  logic [31:0] mem_if_addr;
  logic        mem_if_ready;
  logic [31:0] mem_inst;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  logic [31:0] exp_q [$];

  // Reference model: one entry per line, addressed by the spec's index/tag split.
  bit          m_valid [64];
  logic [9:0]  m_tag   [64];
  logic [31:0] m_data  [64];
  logic [31:0] m_last_inst;
  int          n_hit;
  int          n_miss;

  icache_dm dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clear         (clear),
    .if_enable     (if_enable),
    .if_addr       (if_addr),
    .if_ready      (if_ready),
    .inst          (inst),
    .mem_if_enable (mem_if_enable),
    .mem_if_addr   (mem_if_addr),
    .mem_if_ready  (mem_if_ready),
    .mem_inst      (mem_inst)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:2] == 30'h40) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_last_inst = 32'h0;
    n_hit  = 0;
    n_miss = 0;
  endtask

  // Monitor: every if_ready pulse must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (rst_in && if_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected_if_ready: got inst %h, want no response", inst);
      end else begin
        check("inst", inst, exp_q.pop_front());
      end
    end
  end

  task automatic recover();
    clear        = 1'b1;
    if_enable    = 1'b0;
    mem_if_ready = 1'b0;
    @(negedge clk_in);
    clear = 1'b0;
    exp_q.delete();
  endtask

  // Drives one decoder fetch and plays memctrl for any refill it causes.
  task automatic fetch(input logic [31:0] addr, input int delay, input bit do_clear, input int freeze);
    int          idx;
    logic [9:0]  tg;
    bit          unc;
    bit          hit;
    logic [31:0] word;
    idx = int'(addr[7:2]);
    tg  = addr[17:8];
    unc = (addr[17:16] == 2'b11);
    hit = !unc && m_valid[idx] && (m_tag[idx] == tg);
    @(negedge clk_in);
    if_enable = 1'b1;
    if_addr   = addr;
    if (hit) begin
      n_hit++;
      exp_q.push_back(m_data[idx]);
      m_last_inst = m_data[idx];
      @(negedge clk_in);
      check("hit_latency_if_ready", 32'(if_ready), 32'd1);
      check("hit_no_refill", 32'(mem_if_enable), 32'd0);
      if_enable = 1'b0;
      if (!if_ready) recover();
    end else begin
      n_miss++;
      word = mem_word(addr);
      @(negedge clk_in);
      check("miss_mem_enable", 32'(mem_if_enable), 32'd1);
      check("miss_mem_addr", mem_if_addr, {addr[31:2], 2'b00});
      repeat (delay) @(negedge clk_in);
      if (freeze > 0) begin
        rdy_in       = 1'b0;
        mem_if_ready = 1'b1;
        mem_inst     = ~word;
        repeat (freeze) @(negedge clk_in);
        mem_if_ready = 1'b0;
        rdy_in       = 1'b1;
        check("freeze_mem_enable", 32'(mem_if_enable), 32'd1);
        check("freeze_mem_addr", mem_if_addr, {addr[31:2], 2'b00});
        check("freeze_if_ready", 32'(if_ready), 32'd0);
        check("freeze_inst_hold", inst, m_last_inst);
      end
      check("refill_hold_enable", 32'(mem_if_enable), 32'd1);
      mem_if_ready = 1'b1;
      mem_inst     = word;
      if (do_clear) begin
        clear = 1'b1;
      end else begin
        exp_q.push_back(word);
        m_last_inst = word;
      end
      @(negedge clk_in);
      mem_if_ready = 1'b0;
      clear        = 1'b0;
      if_enable    = 1'b0;
      check("refill_mem_enable_drop", 32'(mem_if_enable), 32'd0);
      if (do_clear) begin
        check("clear_no_if_ready", 32'(if_ready), 32'd0);
      end else begin
        check("refill_if_ready_latency", 32'(if_ready), 32'd1);
        if (!unc) begin
          m_valid[idx] = 1'b1;
          m_tag[idx]   = tg;
          m_data[idx]  = word;
        end
        if (!if_ready) recover();
      end
    end
  endtask

  task automatic applyStimulus();
    logic [9:0]  tags [5];
    logic [13:0] upper;
    logic [31:0] a;
    tags[0] = 10'h001;
    tags[1] = 10'h002;
    tags[2] = 10'h0A5;
    tags[3] = 10'h3C4;
    tags[4] = 10'h300;
    for (int n = 0; n < 250; n++) begin
      upper = ($urandom_range(0, 7) == 0) ? 14'($urandom) : 14'h0;
      a = {upper, tags[$urandom_range(0, 4)], 6'($urandom_range(0, 7)), 2'($urandom)};
      fetch(a, $urandom_range(0, 4), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
    end
  endtask

  task automatic checkOutput();
    @(negedge clk_in);
    @(negedge clk_in);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef ICACHE_STATS_EN
    check("hit_cnt", hit_cnt, 32'(n_hit));
    check("miss_cnt", miss_cnt, 32'(n_miss));
`endif
  endtask

  initial begin
    rst_in       = 1'b0;
    rdy_in       = 1'b1;
    clear        = 1'b0;
    if_enable    = 1'b0;
    if_addr      = 32'h0;
    mem_if_ready = 1'b0;
    mem_inst     = 32'h0;
    model_reset();
    repeat (3) @(negedge clk_in);
    check("reset_if_ready", 32'(if_ready), 32'd0);
    check("reset_inst", inst, 32'd0);
    check("reset_mem_enable", 32'(mem_if_enable), 32'd0);
    check("reset_mem_addr", mem_if_addr, 32'd0);
    rst_in = 1'b1;

    fetch(32'h0000_0100, 5, 1'b0, 0);
    fetch(32'h0000_0100, 0, 1'b0, 0);
    fetch(32'h0000_0200, 2, 1'b0, 0);
    fetch(32'h0000_0100, 1, 1'b0, 0);

    fetch(32'h0000_0104, 2, 1'b1, 0);
    fetch(32'h0000_0104, 1, 1'b0, 0);
    fetch(32'h0000_0104, 0, 1'b0, 0);

    fetch(32'h0003_0000, 1, 1'b0, 0);
    fetch(32'h0003_0000, 2, 1'b0, 3);

    // Asynchronous reset while a refill is outstanding.
    @(negedge clk_in);
    if_enable = 1'b1;
    if_addr   = 32'h0000_02A8;
    @(negedge clk_in);
    check("pre_reset_mem_enable", 32'(mem_if_enable), 32'd1);
    #2 rst_in = 1'b0;
    #1;
    check("async_reset_if_ready", 32'(if_ready), 32'd0);
    check("async_reset_inst", inst, 32'd0);
    check("async_reset_mem_enable", 32'(mem_if_enable), 32'd0);
    check("async_reset_mem_addr", mem_if_addr, 32'd0);
    if_enable = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    fetch(32'h0000_0100, 1, 1'b0, 0);

    applyStimulus();
    checkOutput();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
